regfile_sb: RTL
===============

Name: regfile_sb

Overview:
- Parametrised general-purpose register file for the pipelined MIPS core.
- Provides NR independent read ports, one write port, and an optional same-cycle write-to-read bypass.
- Adds a per-register busy scoreboard: decode sets a bit when an instruction with a destination issues, and writeback clears it.
- Sits between decode (reads, issue) and writeback (writes); the hazard unit consumes rd_busy to stall.

Parameters:
- W, 32, data width in bits.
- DEPTH, 32, number of registers; must be a power of two, at least 2.
- AW, 5, address width; must equal log2(DEPTH).
- NR, 2, number of read ports, 1..4.

Ports:
- CLK  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high.
- rd_addr  input  NR*AW  read addresses; port i occupies [i*AW +: AW].
- rd_data  output  NR*W  read data; port i occupies [i*W +: W].
- rd_busy  output  NR  port i source has a write outstanding.
- wr_en  input  1  writeback strobe.
- wr_addr  input  AW  writeback destination.
- wr_data  input  W  writeback data.
- issue_en  input  1  an instruction with a destination issues this cycle.
- issue_addr  input  AW  destination of the issuing instruction.
- busy_cnt  output  AW+1  registered count of busy registers.
- err_waw  output  1  registered one-cycle pulse: issue to an already-busy register not being cleared this cycle.

Behaviour:
- Reset:
  - One CLK edge with reset=1 clears all DEPTH registers and all busy bits.
  - busy_cnt=0, err_waw=0.
  - wr_en and issue_en are ignored in that cycle.
- Register 0:
  - Reads as 0 on every port.
  - Writes are dropped.
  - Issue to address 0 never sets busy; rd_busy for address 0 is always 0.
- Write:
  - On a CLK edge with wr_en=1 and wr_addr!=0, regs[wr_addr] <= wr_data.
  - A data value of 0 is written like any other value.
- Read:
  - Combinational, zero latency.
  - rd_data[i] = regs[rd_addr[i]], subject to bypass (see Optional Feature).
- Scoreboard next-state, per address a!=0:
  - set = issue_en and issue_addr==a.
  - clr = wr_en and wr_addr==a.
  - busy[a] <= set ? 1 : (clr ? 0 : busy[a]).
  - When set and clr coincide, busy stays 1, because the new producer is in flight.
- rd_busy[i]:
  - rd_busy[i] = busy[rd_addr[i]] with the bypass override (see Optional Feature).
  - A busy bit set by issue is visible on rd_busy from the next cycle.
- err_waw:
  - Registered.
  - Asserted the cycle after issue_en=1 with issue_addr!=0, busy[issue_addr]=1 and not (wr_en and wr_addr==issue_addr).
  - The scoreboard still holds busy=1; it does not count producers.
- busy_cnt:
  - Popcount of the busy vector after the update.
  - Changes one cycle after the causing edge; range 0..DEPTH-1.
- Out-of-order writeback to a non-busy register:
  - Data is written and busy stays 0.
  - No error is flagged.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined:
  - If wr_en=1, wr_addr!=0 and rd_addr[i]==wr_addr, then rd_data[i]=wr_data in the same cycle.
  - rd_busy[i] is forced to 0 for that port in that cycle.
  - Register 0 is still forced to 0.
- Undefined:
  - rd_data returns the stored value only; the write becomes visible the cycle after the edge.
  - rd_busy[i] follows busy[] unmodified, so the hazard unit stalls one extra cycle.

Decomposition:
- Package regfile_pkg holds:
  - RF_W=32, RF_DEPTH=32, RF_AW=5, RF_NR=2.
  - The zero-register address constant REG_ZERO=0.
- One sub-module, regfile_read_port:
  - Implements the single-port mux, the bypass compare and the rd_busy override.
  - Instanced NR times in a generate loop.
- Storage, scoreboard and popcount stay in regfile_sb.

Test Plan:
- Reset with all registers pre-written to 0xFFFFFFFF, then release -> every rd_data=0, rd_busy=0, busy_cnt=0.
- Write r5=0x00000000 after r5=0x12345678 -> r5 reads 0x00000000; write r0=0xDEADBEEF -> r0 reads 0.
- Same-cycle wr r7=0xCAFEF00D with rd_addr[0]=7:
  - With REGFILE_BYPASS_EN, rd_data[0]=0xCAFEF00D and rd_busy[0]=0 in that cycle.
  - Without it, old value that cycle and new value the next.
- issue r3, then r3 busy for 4 cycles, then wr r3=0x55 -> rd_busy=1 for cycles 1..4, busy_cnt 1 then 0, r3=0x55.
- issue r9 while r9 busy and no write to r9 -> err_waw=1 for exactly one cycle, busy_cnt unchanged at 1.
- Same-cycle issue r4 and wr r4 with r4 busy -> r4 stays busy, err_waw=0, data written. Assert reset mid-sequence with 3 busy -> busy_cnt=0 the next cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the register file with busy scoreboard.
package regfile_pkg;

    localparam int RF_W     = 32;
    localparam int RF_DEPTH = 32;
    localparam int RF_AW    = 5;
    localparam int RF_NR    = 2;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: register mux, register-0 forcing and, when
// REGFILE_BYPASS_EN is defined, same-cycle write bypass with busy override.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int W     = RF_W,
    parameter int DEPTH = RF_DEPTH,
    parameter int AW    = RF_AW
) (
    input  logic [DEPTH-1:0][W-1:0] regs_i,
    input  logic [DEPTH-1:0]        busy_i,
    input  logic [AW-1:0]           rd_addr_i,
`ifdef REGFILE_BYPASS_EN
    input  logic                    wr_en_i,
    input  logic [AW-1:0]           wr_addr_i,
    input  logic [W-1:0]            wr_data_i,
`endif
    output logic [W-1:0]            rd_data_o,
    output logic                    rd_busy_o
);

    logic is_zero;

`ifdef REGFILE_BYPASS_EN
    logic hit;
    assign hit = wr_en_i && (wr_addr_i != AW'(REG_ZERO)) && (wr_addr_i == rd_addr_i);
`endif

    assign is_zero = (rd_addr_i == AW'(REG_ZERO));

    always_comb begin
        rd_data_o = is_zero ? '0 : regs_i[rd_addr_i];
        rd_busy_o = !is_zero && busy_i[rd_addr_i];
`ifdef REGFILE_BYPASS_EN
        // Forwarded data satisfies the consumer, so it must not stall.
        if (hit) begin
            rd_data_o = wr_data_i;
            rd_busy_o = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/regfile_sb.sv
// MIPS register file: NR read ports, one write port, per-register busy
// scoreboard with WAW error pulse. Optional bypass: define REGFILE_BYPASS_EN.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int W     = RF_W,
    parameter int DEPTH = RF_DEPTH,
    parameter int AW    = RF_AW,
    parameter int NR    = RF_NR
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [NR*AW-1:0]  rd_addr,
    output logic [NR*W-1:0]   rd_data,
    output logic [NR-1:0]     rd_busy,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [W-1:0]      wr_data,
    input  logic              issue_en,
    input  logic [AW-1:0]     issue_addr,
    output logic [AW:0]       busy_cnt,
    output logic              err_waw
);

    logic [DEPTH-1:0][W-1:0] regs_q;
    logic [DEPTH-1:0]        busy_q, busy_d;
    logic [AW:0]             cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic                    wr_ok;

    assign wr_ok = wr_en && (wr_addr != AW'(REG_ZERO));

    // A coinciding issue wins over the clear: the new producer is in flight.
    always_comb begin
        busy_d    = '0;
        for (int a = 1; a < DEPTH; a++) begin
            busy_d[a] = (issue_en && (issue_addr == AW'(a)))
                     || (busy_q[a] && !(wr_en && (wr_addr == AW'(a))));
        end
        cnt_d = '0;
        for (int a = 0; a < DEPTH; a++) begin
            cnt_d = cnt_d + {{AW{1'b0}}, busy_d[a]};
        end
        err_d = issue_en && (issue_addr != AW'(REG_ZERO)) && busy_q[issue_addr]
             && !(wr_en && (wr_addr == issue_addr));
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            regs_q <= '0;
            busy_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            if (wr_ok) begin
                regs_q[wr_addr] <= wr_data;
            end
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign busy_cnt = cnt_q;
    assign err_waw  = err_q;

    for (genvar i = 0; i < NR; i++) begin : g_rd
        regfile_read_port #(
            .W     (W),
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_port (
            .regs_i    (regs_q),
            .busy_i    (busy_q),
            .rd_addr_i (rd_addr[i*AW +: AW]),
`ifdef REGFILE_BYPASS_EN
            .wr_en_i   (wr_en),
            .wr_addr_i (wr_addr),
            .wr_data_i (wr_data),
`endif
            .rd_data_o (rd_data[i*W +: W]),
            .rd_busy_o (rd_busy[i])
        );
    end

endmodule
